dm: RTL and testbench
=====================

DM -- requirements
Module: dm

Interface
REQ-001 clk  in  1  system clock; all state changes on the rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 dmi_start  in  1  DMI request level from the DTM, already synchronised to clk.
REQ-004 dmi_op  in  2  operation: 0 nop, 1 read, 2 write, 3 reserved (treated as nop).
REQ-005 dmi_address  in  7 ([40:34])  DM register address.
REQ-006 dmi_data_o  in  32 ([33:2])  write data from the DTM.
REQ-007 dmi_data_i  out  32 ([33:2])  read data to the DTM.
REQ-008 dmi_finish  out  1  request-complete level to the DTM.
REQ-009 halted  in  1  core is halted.
REQ-010 running  in  1  core is running.
REQ-011 haltreq  out  1  halt request to the core; level.
REQ-012 resumereq  out  1  resume request to the core; level.
REQ-013 resethaltreq  out  1  halt-on-reset request to the core.
REQ-014 ndmreset  out  1  system reset request, excluding the debug transport.

Function
REQ-015 DMI request handshake: four-phase.
- A request is accepted on the first clk edge where dmi_start=1 and the registered previous dmi_start=0.
- The access is performed on that edge.
- dmi_finish=1 and dmi_data_i are valid from the following cycle.
- Both are held until dmi_start=0 is sampled; dmi_finish returns to 0 one cycle later.
REQ-016 While dmi_finish=1, no new request is accepted; dmi_start held high never causes a second access.
REQ-017 Read data: dmi_data_i = addressed register value; dmi_data_i=0 for writes, nops and unmapped addresses.
REQ-018 Writes to unmapped or read-only addresses have no effect.
REQ-019 dmcontrol (0x10) write fields:
- bit31 haltreq: stored; the haltreq output follows it.
- bit30 resumereq.
- bit3 setresethaltreq.
- bit2 clrresethaltreq.
- bit1 ndmreset: stored; the ndmreset output follows it.
- bit0 dmactive: stored.
REQ-020 dmactive is read back only and does not gate any other field.
REQ-021 dmcontrol read returns haltreq, ndmreset and dmactive in place; all other bits read 0.
REQ-022 A write with resumereq=1 and haltreq=0:
- sets the resumereq output;
- clears resumeack.
A write with haltreq=1 ignores resumereq.
REQ-023 resumereq output clears, and resumeack sets, on the first cycle with running=1 and halted=0 while resumereq=1.
REQ-024 resethaltreq:
- setresethaltreq=1 sets it;
- clrresethaltreq=1 clears it;
- both set in the same write: value unchanged.
REQ-025 dmstatus (0x11), read-only:
- bit17/16 allresumeack/anyresumeack = resumeack;
- bit11/10 allrunning/anyrunning = running;
- bit9/8 allhalted/anyhalted = halted;
- bit7 authenticated = 1;
- bits3:0 version = 2;
- all other bits 0.
REQ-026 hartinfo (0x12) reads 0.

Reset
REQ-027 rst_n low sets all of these to 0: haltreq, resumereq, resethaltreq, ndmreset, dmactive, resumeack, dmi_finish, dmi_data_i, the edge-detect register and the data registers.
REQ-028 Reset asserted mid-request aborts the request; after release, a request is accepted only on a fresh rising edge of dmi_start.

Configuration
REQ-029 DM_DATA_REGS_EN defined: data0 (0x04) and data1 (0x05) are 32-bit read/write scratch registers.
REQ-030 DM_DATA_REGS_EN undefined: 0x04 and 0x05 are unmapped (read 0, writes ignored).

Structure
REQ-031 Package dm_pkg holds the following; dm has no sub-modules:
- register address constants (0x04, 0x05, 0x10, 0x11, 0x12);
- the dmi_op enum;
- packed dmcontrol_t and dmstatus_t.

Verification
REQ-032 Write 0x10=0x80000000, with core then asserting halted=1, running=0 -> haltreq=1; dmi_finish=1 one cycle after accept.
REQ-033 Read 0x11 while halted=1, running=0 -> dmi_data_i=0x00000382.
REQ-034 Write 0x10=0x40000000, with core raising running=1, halted=0 -> haltreq=0; resumereq pulses until running; subsequent 0x11 read = 0x00030C82.
REQ-035 Write 0x10=0x00000008, then 0x00000004 -> resethaltreq 1 then 0; 0x0000000C leaves it unchanged.
REQ-036 Hold dmi_start high for 10 cycles -> exactly one access; dmi_finish low one cycle after dmi_start falls; read of 0x7F returns 0.
REQ-037 With DM_DATA_REGS_EN: write 0x04=0xDEADBEEF, then read -> 0xDEADBEEF; without the macro the read returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: DMI register map, operation encoding and dmcontrol/dmstatus layouts.
package dm_pkg;
  localparam logic [6:0] ADDR_DATA0     = 7'h04;
  localparam logic [6:0] ADDR_DATA1     = 7'h05;
  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO  = 7'h12;
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_t;
  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic [25:0] rsvd;
    logic        setresethaltreq;
    logic        clrresethaltreq;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;
  typedef struct packed {
    logic [13:0] rsvd_hi;
    logic        allresumeack;
    logic        anyresumeack;
    logic [3:0]  rsvd_mid;
    logic        allrunning;
    logic        anyrunning;
    logic        allhalted;
    logic        anyhalted;
    logic        authenticated;
    logic [2:0]  rsvd_lo;
    logic [3:0]  version;
  } dmstatus_t;
endpackage

// File: rtl/dm_if.sv
// dm_if: DMI request/response bundle between the debug transport (master) and the DM (slave).
interface dm_if;
  import dm_pkg::*;
  logic        dmi_start;
  dmi_op_t     dmi_op;
  logic [6:0]  dmi_address;
  logic [31:0] dmi_data_o;
  logic [31:0] dmi_data_i;
  logic        dmi_finish;
  modport master (output dmi_start, dmi_op, dmi_address, dmi_data_o, input dmi_data_i, dmi_finish);
  modport slave (input dmi_start, dmi_op, dmi_address, dmi_data_o, output dmi_data_i, dmi_finish);
endinterface

// File: rtl/dm.sv
// dm: minimal debug module with four-phase DMI handshake and halt/resume/reset control.
// Define DM_DATA_REGS_EN to map data0/data1 scratch registers at 0x04/0x05.
module dm
  import dm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  dm_if.slave  dmi,
  input  logic halted,
  input  logic running,
  output logic haltreq,
  output logic resumereq,
  output logic resethaltreq,
  output logic ndmreset
);
  typedef enum logic {S_IDLE, S_DONE} state_t;
  state_t      state, state_nx;
  logic        start_q, armed, dmactive, resumeack, accept, is_read, is_write;
  logic [31:0] rdata, rdata_q;
  dmcontrol_t  wctl, rctl;
  dmstatus_t   st;
  logic        unused_rsvd;
`ifdef DM_DATA_REGS_EN
  logic [31:0] data0, data1;
`endif
  assign wctl = dmi.dmi_data_o;
  assign unused_rsvd = ^wctl.rsvd;
  assign is_read = dmi.dmi_op == OP_READ;
  assign is_write = dmi.dmi_op == OP_WRITE;
  assign dmi.dmi_finish = state == S_DONE;
  assign dmi.dmi_data_i = rdata_q;
  // armed blocks a request whose dmi_start was already high when reset released
  always_comb begin
    accept = state == S_IDLE && dmi.dmi_start && !start_q && armed;
    state_nx = accept ? S_DONE : (state == S_DONE && !dmi.dmi_start) ? S_IDLE : state;
  end
  always_comb begin
    rctl = '0;
    rctl.haltreq = haltreq;
    rctl.ndmreset = ndmreset;
    rctl.dmactive = dmactive;
    st = '0;
    st.allresumeack = resumeack;
    st.anyresumeack = resumeack;
    st.allrunning = running;
    st.anyrunning = running;
    st.allhalted = halted;
    st.anyhalted = halted;
    st.authenticated = 1'b1;
    st.version = 4'd2;
    rdata = '0;
    if (is_read)
      case (dmi.dmi_address)
        ADDR_DMCONTROL: rdata = rctl;
        ADDR_DMSTATUS:  rdata = st;
`ifdef DM_DATA_REGS_EN
        ADDR_DATA0:     rdata = data0;
        ADDR_DATA1:     rdata = data1;
        ADDR_HARTINFO:  rdata = '0;
`else
        ADDR_DATA0, ADDR_DATA1, ADDR_HARTINFO: rdata = '0;
`endif
        default:        rdata = '0;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      start_q <= 1'b0;
      armed <= 1'b0;
      rdata_q <= '0;
      haltreq <= 1'b0;
      resumereq <= 1'b0;
      resethaltreq <= 1'b0;
      ndmreset <= 1'b0;
      dmactive <= 1'b0;
      resumeack <= 1'b0;
    end else begin
      state <= state_nx;
      start_q <= dmi.dmi_start;
      armed <= armed | !dmi.dmi_start;
      rdata_q <= accept ? rdata : (state_nx == S_IDLE) ? '0 : rdata_q;
      if (resumereq && running && !halted) begin
        resumereq <= 1'b0;
        resumeack <= 1'b1;
      end
      if (accept && is_write && dmi.dmi_address == ADDR_DMCONTROL) begin
        haltreq <= wctl.haltreq;
        ndmreset <= wctl.ndmreset;
        dmactive <= wctl.dmactive;
        if (wctl.resumereq && !wctl.haltreq) begin
          resumereq <= 1'b1;
          resumeack <= 1'b0;
        end
        if (wctl.setresethaltreq != wctl.clrresethaltreq) resethaltreq <= wctl.setresethaltreq;
      end
    end
`ifdef DM_DATA_REGS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
    end else if (accept && is_write) begin
      if (dmi.dmi_address == ADDR_DATA0) data0 <= dmi.dmi_data_o;
      if (dmi.dmi_address == ADDR_DATA1) data1 <= dmi.dmi_data_o;
    end
`endif
endmodule

// File: tb/tb_dm.sv
// tb_dm: directed self-checking bench for dm (honours DM_DATA_REGS_EN for data0/data1 expectations).
module tb_dm;
  import dm_pkg::*;
  logic clk, rst_n, halted, running;
  logic haltreq, resumereq, resethaltreq, ndmreset;
  logic [31:0] rd;
  int tests = 0, fails = 0, pulses;
  dm_if dmi();
  dm u_dm (
    .clk(clk), .rst_n(rst_n), .dmi(dmi), .halted(halted), .running(running),
    .haltreq(haltreq), .resumereq(resumereq), .resethaltreq(resethaltreq), .ndmreset(ndmreset)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input dmi_op_t op, input logic [6:0] a, input logic [31:0] wd, output logic [31:0] r);
    @(negedge clk);
    dmi.dmi_start = 1'b1;
    dmi.dmi_op = op;
    dmi.dmi_address = a;
    dmi.dmi_data_o = wd;
    @(negedge clk);
    chk("finish_after_accept", {31'd0, dmi.dmi_finish}, 32'd1);
    r = dmi.dmi_data_i;
    dmi.dmi_start = 1'b0;
    @(negedge clk);
    chk("finish_drop", {31'd0, dmi.dmi_finish}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    halted = 1'b0;
    running = 1'b0;
    dmi.dmi_start = 1'b0;
    dmi.dmi_op = OP_NOP;
    dmi.dmi_address = '0;
    dmi.dmi_data_o = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {28'd0, haltreq, resumereq, resethaltreq, ndmreset}, 32'd0);
    chk("rst_finish", {31'd0, dmi.dmi_finish}, 32'd0);
    chk("rst_data", dmi.dmi_data_i, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(OP_WRITE, 7'h10, 32'h8000_0000, rd);
    chk("write_data_zero", rd, 32'd0);
    chk("haltreq_set", {31'd0, haltreq}, 32'd1);
    halted = 1'b1;
    xfer(OP_READ, 7'h11, 32'd0, rd);
    chk("dmstatus_halted", rd, 32'h0000_0382);
    xfer(OP_READ, 7'h10, 32'd0, rd);
    chk("dmcontrol_rd_halt", rd, 32'h8000_0000);
    xfer(OP_WRITE, 7'h10, 32'h4000_0000, rd);
    chk("haltreq_clr", {31'd0, haltreq}, 32'd0);
    chk("resumereq_set", {31'd0, resumereq}, 32'd1);
    halted = 1'b0;
    running = 1'b1;
    @(negedge clk);
    chk("resumereq_done", {31'd0, resumereq}, 32'd0);
    xfer(OP_READ, 7'h11, 32'd0, rd);
    chk("dmstatus_running", rd, 32'h0003_0C82);
    xfer(OP_WRITE, 7'h10, 32'hC000_0000, rd);
    chk("halt_wins_haltreq", {31'd0, haltreq}, 32'd1);
    chk("halt_wins_resumereq", {31'd0, resumereq}, 32'd0);
    xfer(OP_READ, 7'h11, 32'd0, rd);
    chk("resumeack_kept", rd, 32'h0003_0C82);
    xfer(OP_WRITE, 7'h10, 32'h0000_0003, rd);
    chk("ndmreset_set", {31'd0, ndmreset}, 32'd1);
    xfer(OP_READ, 7'h10, 32'd0, rd);
    chk("dmcontrol_rd_ndm", rd, 32'h0000_0003);
    xfer(OP_WRITE, 7'h10, 32'h0000_0000, rd);
    chk("ndmreset_clr", {30'd0, ndmreset, haltreq}, 32'd0);
    xfer(OP_WRITE, 7'h10, 32'h0000_0008, rd);
    chk("resethalt_set", {31'd0, resethaltreq}, 32'd1);
    xfer(OP_WRITE, 7'h10, 32'h0000_000C, rd);
    chk("resethalt_both_1", {31'd0, resethaltreq}, 32'd1);
    xfer(OP_WRITE, 7'h10, 32'h0000_0004, rd);
    chk("resethalt_clr", {31'd0, resethaltreq}, 32'd0);
    xfer(OP_WRITE, 7'h10, 32'h0000_000C, rd);
    chk("resethalt_both_0", {31'd0, resethaltreq}, 32'd0);
    // a repeated access would re-raise resumereq, since running clears it every time
    @(negedge clk);
    dmi.dmi_start = 1'b1;
    dmi.dmi_op = OP_WRITE;
    dmi.dmi_address = 7'h10;
    dmi.dmi_data_o = 32'h4000_0000;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resumereq) pulses++;
      if (i == 0) chk("hold_first_finish", {31'd0, dmi.dmi_finish}, 32'd1);
    end
    chk("hold_single_access", pulses, 32'd1);
    chk("hold_finish_kept", {31'd0, dmi.dmi_finish}, 32'd1);
    dmi.dmi_start = 1'b0;
    @(negedge clk);
    chk("hold_finish_drop", {31'd0, dmi.dmi_finish}, 32'd0);
    xfer(OP_READ, 7'h7F, 32'd0, rd);
    chk("unmapped_read", rd, 32'd0);
    xfer(OP_READ, 7'h12, 32'd0, rd);
    chk("hartinfo_read", rd, 32'd0);
    xfer(OP_NOP, 7'h11, 32'd0, rd);
    chk("nop_data", rd, 32'd0);
    xfer(OP_RSVD, 7'h11, 32'd0, rd);
    chk("rsvd_op_data", rd, 32'd0);
    xfer(OP_WRITE, 7'h04, 32'hDEAD_BEEF, rd);
    xfer(OP_WRITE, 7'h05, 32'h1234_5678, rd);
    xfer(OP_READ, 7'h04, 32'd0, rd);
`ifdef DM_DATA_REGS_EN
    chk("data0_read", rd, 32'hDEAD_BEEF);
    xfer(OP_READ, 7'h05, 32'd0, rd);
    chk("data1_read", rd, 32'h1234_5678);
`else
    chk("data0_unmapped", rd, 32'd0);
    xfer(OP_READ, 7'h05, 32'd0, rd);
    chk("data1_unmapped", rd, 32'd0);
`endif
    @(negedge clk);
    dmi.dmi_start = 1'b1;
    dmi.dmi_op = OP_WRITE;
    dmi.dmi_address = 7'h10;
    dmi.dmi_data_o = 32'h8000_0001;
    @(negedge clk);
    chk("midreq_finish", {31'd0, dmi.dmi_finish}, 32'd1);
    chk("midreq_haltreq", {31'd0, haltreq}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_finish", {31'd0, dmi.dmi_finish}, 32'd0);
    chk("async_rst_outputs", {28'd0, haltreq, resumereq, resethaltreq, ndmreset}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_reaccept_finish", {31'd0, dmi.dmi_finish}, 32'd0);
    chk("no_reaccept_haltreq", {31'd0, haltreq}, 32'd0);
    dmi.dmi_start = 1'b0;
    @(negedge clk);
    xfer(OP_READ, 7'h10, 32'd0, rd);
    chk("post_rst_dmcontrol", rd, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
